// File: rtl/mux_n_scan.sv
// mux_n_scan: N-channel registered mux with manual select and round-robin auto-scan.
// Optional macro MUX_SCAN_SKIP_EN adds ch_mask so the scan skips disabled channels.
module mux_n_scan #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int DW = 4,
  localparam int SW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SW-1:0]    sel,
  input  logic             load_sel,
  input  logic             mode,
  input  logic [DW-1:0]    dwell,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [N-1:0]     ch_mask,
`endif
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [SW-1:0]    cur_ch,
  output logic             wrap,
  output logic             sel_err
);
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q;
  logic [SW-1:0]    cur_ch_q, cur_ch_d, adv_ch;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d, sel_err_q, sel_err_d, adv_wrap, sel_ok;

  assign sel_ok = int'(sel) < N;

`ifdef MUX_SCAN_SKIP_EN
  logic found;
  // channel i steps above c, folded back into 0..N-1
  function automatic logic [SW-1:0] step(input logic [SW-1:0] c, input int i);
    int s = int'(c) + i;
    return SW'(s >= N ? s - N : s);
  endfunction
  // nearest enabled channel above cur_ch, searched circularly; hold if none enabled
  always_comb begin
    adv_ch = cur_ch_q;
    adv_wrap = 1'b0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && ch_mask[step(cur_ch_q, i)]) begin
        found = 1'b1;
        adv_ch = step(cur_ch_q, i);
        adv_wrap = int'(cur_ch_q) + i >= N;
      end
    end
  end
`else
  assign adv_wrap = cur_ch_q == SW'(N - 1);
  assign adv_ch = adv_wrap ? '0 : cur_ch_q + 1'b1;
`endif

  // channel selection priority: manual load, bad load, scan advance, scan hold, manual hold
  always_comb begin
    cur_ch_d = cur_ch_q;
    cnt_d = cnt_q;
    wrap_d = 1'b0;
    sel_err_d = 1'b0;
    if (load_sel) begin
      if (sel_ok) begin
        cur_ch_d = sel;
        cnt_d = '0;
      end else sel_err_d = 1'b1;
    end else if (mode) begin
      if (cnt_q == dwell) begin
        cur_ch_d = adv_ch;
        wrap_d = adv_wrap;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
    end else cnt_d = '0;
    y_d = in_data[cur_ch_d*WIDTH +: WIDTH];
  end

  // output and scan-state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      y_valid_q <= 1'b0;
      cur_ch_q <= '0;
      cnt_q <= '0;
      wrap_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      y_q <= y_d;
      y_valid_q <= 1'b1;
      cur_ch_q <= cur_ch_d;
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign y = y_q;
  assign y_valid = y_valid_q;
  assign cur_ch = cur_ch_q;
  assign wrap = wrap_q;
  assign sel_err = sel_err_q;
endmodule

// File: tb/tb_mux_n_scan.sv
// tb_mux_n_scan: randomized self-checking bench for mux_n_scan against a rule-level model.
module tb_mux_n_scan;
  localparam int N = 4, W = 8, DW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N*W-1:0] in_data;
  logic [1:0] sel;
  logic load_sel, mode;
  logic [DW-1:0] dwell;
  logic [N-1:0] ch_mask;
  logic [W-1:0] y;
  logic y_valid, wrap, sel_err;
  logic [1:0] cur_ch;
  logic [47:0] in6;
  logic [39:0] in5;
  logic [2:0] sel3, c6, c5;
  logic ld3;
  logic [W-1:0] y6, y5;
  logic v6, v5, w6, w5, e6, e5;
  int checks = 0, failures = 0;
  int m_ch, m_cnt;
  logic [W-1:0] e_y;
  logic e_valid, e_wrap, e_err;

  mux_n_scan #(.N(N), .WIDTH(W), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .in_data(in_data),
    .sel(sel), .load_sel(load_sel), .mode(mode), .dwell(dwell),
`ifdef MUX_SCAN_SKIP_EN
    .ch_mask(ch_mask),
`endif
    .y(y), .y_valid(y_valid), .cur_ch(cur_ch), .wrap(wrap), .sel_err(sel_err));
  mux_n_scan #(.N(6), .WIDTH(W), .DW(DW)) dut6 (.clk(clk), .rst_n(rst_n), .in_data(in6),
    .sel(sel3), .load_sel(ld3), .mode(1'b0), .dwell(4'd0),
`ifdef MUX_SCAN_SKIP_EN
    .ch_mask(6'h3f),
`endif
    .y(y6), .y_valid(v6), .cur_ch(c6), .wrap(w6), .sel_err(e6));
  mux_n_scan #(.N(5), .WIDTH(W), .DW(DW)) dut5 (.clk(clk), .rst_n(rst_n), .in_data(in5),
    .sel(sel3), .load_sel(ld3), .mode(1'b0), .dwell(4'd0),
`ifdef MUX_SCAN_SKIP_EN
    .ch_mask(5'h1f),
`endif
    .y(y5), .y_valid(v5), .cur_ch(c5), .wrap(w5), .sel_err(e5));

  // one rising edge; the model applies the selection rules to the inputs seen at that edge
  task automatic tick();
    bit f;
    @(posedge clk);
    e_wrap = 1'b0;
    e_err = 1'b0;
    if (load_sel) begin
      if (int'(sel) < N) begin m_ch = int'(sel); m_cnt = 0; end
      else e_err = 1'b1;
    end else if (mode) begin
      if (m_cnt == int'(dwell)) begin
`ifdef MUX_SCAN_SKIP_EN
        f = 0;
        for (int i = 1; i <= N; i++)
          if (!f && ((ch_mask >> ((m_ch + i) % N)) & 1) != 0) begin
            f = 1;
            e_wrap = (m_ch + i) >= N;
            m_ch = (m_ch + i) % N;
          end
`else
        e_wrap = m_ch == N - 1;
        m_ch = (m_ch + 1) % N;
`endif
        m_cnt = 0;
      end else m_cnt = (m_cnt + 1) % (1 << DW);
    end else m_cnt = 0;
    e_y = in_data[m_ch*W +: W];
    e_valid = 1'b1;
    #1;
  endtask

  task automatic model_reset();
    m_ch = 0; m_cnt = 0; e_y = '0; e_valid = 0; e_wrap = 0; e_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; in_data = 32'h44332211; mode = 0; load_sel = 0; sel = 0; dwell = 0;
    ch_mask = '1; ld3 = 0; sel3 = 0; in6 = {$urandom, 16'h5a5a}; in5 = {$urandom, 8'hc3};
    model_reset();
    #12;
    checks++; if (y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h exp=00", y); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", y_valid); end
    checks++; if ({cur_ch, wrap, sel_err} !== 4'b0) begin failures++; $display("FAIL reset_state got=%b exp=0000", {cur_ch, wrap, sel_err}); end
    @(negedge clk); rst_n = 1;
    tick();
    checks++; if (y !== 8'h11) begin failures++; $display("FAIL first_y got=%h exp=11", y); end
    checks++; if (y_valid !== 1'b1 || cur_ch !== 2'd0) begin failures++; $display("FAIL first_state got=%b/%0d exp=1/0", y_valid, cur_ch); end
  endtask

  task automatic test_load();
    load_sel = 1; sel = 2;
    tick();
    load_sel = 0;
    checks++; if (y !== 8'h33 || cur_ch !== 2'd2) begin failures++; $display("FAIL load_sel2 got=%h/%0d exp=33/2", y, cur_ch); end
    checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", sel_err); end
    tick();
    checks++; if (cur_ch !== 2'd2) begin failures++; $display("FAIL manual_hold got=%0d exp=2", cur_ch); end
  endtask

  task automatic test_sel_range();
    ld3 = 1; sel3 = 3'd5;
    tick();
    ld3 = 0;
    checks++; if (c6 !== 3'd5 || y6 !== in6[40 +: 8]) begin failures++; $display("FAIL n6_sel5 got=%0d/%h exp=5/%h", c6, y6, in6[40 +: 8]); end
    checks++; if (e6 !== 1'b0) begin failures++; $display("FAIL n6_err got=%b exp=0", e6); end
    checks++; if (c5 !== 3'd0 || y5 !== in5[7:0]) begin failures++; $display("FAIL n5_hold got=%0d/%h exp=0/%h", c5, y5, in5[7:0]); end
    checks++; if (e5 !== 1'b1) begin failures++; $display("FAIL n5_err got=%b exp=1", e5); end
    tick();
    checks++; if (e5 !== 1'b0) begin failures++; $display("FAIL n5_err_pulse got=%b exp=0", e5); end
  endtask

  task automatic test_scan_dwell();
    int wraps = 0;
    int exp_seq[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    load_sel = 1; sel = 0; mode = 1; dwell = 2;
    tick();
    load_sel = 0;
    for (int i = 0; i < 12; i++) begin
      in_data = $urandom;
      tick();
      if (wrap) wraps++;
      checks++; if (cur_ch !== 2'(exp_seq[i]) || wrap !== (i == 11)) begin failures++; $display("FAIL scan_seq[%0d] got=%0d/%b exp=%0d/%b", i, cur_ch, wrap, exp_seq[i], i == 11); end
      checks++; if ({y, y_valid, cur_ch, wrap, sel_err} !== {e_y, e_valid, 2'(m_ch), e_wrap, e_err}) begin failures++; $display("FAIL scan_model[%0d] got=%h exp=%h", i, {y, y_valid, cur_ch, wrap, sel_err}, {e_y, e_valid, 2'(m_ch), e_wrap, e_err}); end
    end
    checks++; if (wraps != 1) begin failures++; $display("FAIL scan_wraps got=%0d exp=1", wraps); end
  endtask

  task automatic test_async_reset();
    mode = 1; dwell = 0; load_sel = 1; sel = 2;
    tick();
    load_sel = 0;
    #3 rst_n = 0;
    #1;
    checks++; if (y !== 8'h00 || cur_ch !== 2'd0 || y_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%0d/%b exp=00/0/0", y, cur_ch, y_valid); end
    model_reset();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      in_data = $urandom;
      tick();
      checks++; if ({y, y_valid, cur_ch, wrap, sel_err} !== {e_y, e_valid, 2'(m_ch), e_wrap, e_err}) begin failures++; $display("FAIL resume[%0d] got=%h exp=%h", i, {y, y_valid, cur_ch, wrap, sel_err}, {e_y, e_valid, 2'(m_ch), e_wrap, e_err}); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_data = $urandom;
      load_sel = $urandom_range(0, 9) == 0;
      sel = 2'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) dwell = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ch_mask = N'($urandom);
      tick();
      checks++; if ({y, y_valid, cur_ch, wrap, sel_err} !== {e_y, e_valid, 2'(m_ch), e_wrap, e_err}) begin failures++; $display("FAIL random[%0d] got=%h exp=%h", i, {y, y_valid, cur_ch, wrap, sel_err}, {e_y, e_valid, 2'(m_ch), e_wrap, e_err}); end
    end
    load_sel = 0;
  endtask

`ifdef MUX_SCAN_SKIP_EN
  task automatic test_skip();
    mode = 1; dwell = 0; ch_mask = 4'b1010;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      tick();
      checks++; if (!(cur_ch == 2'd1 || cur_ch == 2'd3) || wrap !== (cur_ch == 2'd1)) begin failures++; $display("FAIL skip_seq[%0d] got=%0d/%b", i, cur_ch, wrap); end
      checks++; if ({y, cur_ch, wrap} !== {e_y, 2'(m_ch), e_wrap}) begin failures++; $display("FAIL skip_model[%0d] got=%h exp=%h", i, {y, cur_ch, wrap}, {e_y, 2'(m_ch), e_wrap}); end
    end
    ch_mask = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cur_ch !== 2'(m_ch) || wrap !== 1'b0) begin failures++; $display("FAIL skip_none[%0d] got=%0d/%b exp=%0d/0", i, cur_ch, wrap, m_ch); end
    end
    ch_mask = '1;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_sel_range();
    test_scan_dwell();
    test_async_reset();
`ifdef MUX_SCAN_SKIP_EN
    test_skip();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
